// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the 5-stage MIPS core.
// Used by the IF stage and reused by later pipeline registers.
package pipeline_pkg;

  localparam int unsigned XLEN = 32;

  // sll $0,$0,0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats capture.
// A flushed slot keeps the PC fields but carries a NOP with valid cleared.
module if_id_reg
  import pipeline_pkg::*;
#(
  parameter logic [XLEN-1:0] NopInstr = NOP_INSTR
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   stall_i,
  input  logic   flush_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  if_id_t q_q;
  if_id_t q_d;

  always_comb begin
    q_d = q_q;
    if (flush_i) begin
      q_d.instr    = NopInstr;
      q_d.pc       = d_i.pc;
      q_d.pc_plus4 = d_i.pc_plus4;
      q_d.valid    = 1'b0;
    end else if (!stall_i) begin
      q_d = d_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q.instr    <= NopInstr;
      q_q.pc       <= '0;
      q_q.pc_plus4 <= '0;
      q_q.valid    <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational imem,
// and fills the IF/ID register. Redirect beats stall for both PC and IF/ID.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic [31:0]      imem_pc,
  input  logic [31:0]      imem_instr,
  input  logic             stall,
  input  logic             flush,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic [31:0]      if_id_instr,
  output logic [31:0]      if_id_pc,
  output logic [31:0]      if_id_pc_plus4,
  output logic             if_id_valid,
  output logic [CNT_W-1:0] fetch_count
);

  import pipeline_pkg::if_id_t;
  import pipeline_pkg::align_word;

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pc_plus4;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             squash;
  logic             capture;
  if_id_t           if_id_d;
  if_id_t           if_id_q;

  // Redirect targets are silently word-aligned; the low bits never matter.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign pc_plus4 = pc_q + 32'd4;
  assign squash   = redirect_valid | flush;
  assign capture  = ~squash & ~stall;

  always_comb begin
    pc_d = pc_plus4;
    if (redirect_valid) begin
      pc_d = align_word(redirect_pc);
    end else if (stall) begin
      pc_d = pc_q;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (capture) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    if_id_d.instr    = imem_instr;
    if_id_d.pc       = pc_q;
    if_id_d.pc_plus4 = pc_plus4;
    if_id_d.valid    = 1'b1;
  end

  if_id_reg #(
    .NopInstr(NOP_INSTR)
  ) u_if_id_reg (
    .clk_i  (clk),
    .rst_i  (reset),
    .stall_i(stall),
    .flush_i(squash),
    .d_i    (if_id_d),
    .q_o    (if_id_q)
  );

  assign imem_pc        = pc_q;
  assign if_id_instr    = if_id_q.instr;
  assign if_id_pc       = if_id_q.pc;
  assign if_id_pc_plus4 = if_id_q.pc_plus4;
  assign if_id_valid    = if_id_q.valid;
  assign fetch_count    = cnt_q;

endmodule
